// File: rtl/rename_stage_if.sv
// Decode-slot type package and the rename stage bus interface.
// The slave modport is the rename stage view; the master modport is the decode/retire/dispatch side.
package Types;
    typedef struct packed {
        logic        RegWrite;
        logic [4:0]  ARegAddrDst;
        logic [4:0]  ARegAddrSrc0;
        logic [4:0]  ARegAddrSrc1;
        logic [3:0]  AluOp;
        logic        UseImm;
        logic [15:0] Imm;
    } decode_struct;
endpackage

interface rename_stage_if #(
    parameter int PREG_W = 7
);
    import Types::*;

    logic                 i_valid;
    logic                 o_ready;
    decode_struct         i_decode_data [0:1];
    logic                 o_valid;
    logic                 i_ready;
    decode_struct         o_decode_data [0:1];
    logic [PREG_W-1:0]    o_psrc0 [0:1];
    logic [PREG_W-1:0]    o_psrc1 [0:1];
    logic [PREG_W-1:0]    o_pdst [0:1];
    logic [PREG_W-1:0]    o_pold [0:1];
    logic [1:0]           i_free_valid;
    logic [PREG_W-1:0]    i_free_preg [0:1];
    logic [PREG_W:0]      o_free_count;
    logic                 o_free_overflow;

    modport slave (
        input  i_valid, i_decode_data, i_ready, i_free_valid, i_free_preg,
        output o_ready, o_valid, o_decode_data, o_psrc0, o_psrc1, o_pdst, o_pold,
               o_free_count, o_free_overflow
    );

    modport master (
        output i_valid, i_decode_data, i_ready, i_free_valid, i_free_preg,
        input  o_ready, o_valid, o_decode_data, o_psrc0, o_psrc1, o_pdst, o_pold,
               o_free_count, o_free_overflow
    );
endinterface

// File: rtl/rename_stage.sv
// 2-wide register rename: RAT + circular free list, one registered output bundle.
// Optional macro RENAME_FREE_BYPASS_EN lets same-cycle retire returns be allocated immediately.
module rename_stage
    import Types::*;
#(
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 128,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rename_stage_if.slave rn
);
    localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int CNT_W    = PREG_W + 1;
    localparam logic [CNT_W-1:0] FL_FULL = CNT_W'(FL_DEPTH);

    typedef logic [PREG_W-1:0] preg_t;

    function automatic preg_t fl_advance(input preg_t idx, input logic [1:0] n);
        logic [PREG_W:0] sum;
        sum = {1'b0, idx} + {{(PREG_W-1){1'b0}}, n};
        if (sum >= (PREG_W+1)'(FL_DEPTH)) sum = sum - (PREG_W+1)'(FL_DEPTH);
        return sum[PREG_W-1:0];
    endfunction

    preg_t            rat_rd [NUM_AREGS];
    preg_t            fl_rd [FL_DEPTH];
    preg_t            head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;

    logic             valid_reg;
    decode_struct     data_reg [0:1];
    preg_t            psrc0_reg [0:1];
    preg_t            psrc1_reg [0:1];
    preg_t            pdst_reg [0:1];
    preg_t            pold_reg [0:1];

    logic             wr0, wr1;
    logic [4:0]       dst0, dst1, src00, src01, src10, src11;
    logic             need0, need1;
    logic [1:0]       need_cnt;

    assign wr0   = rn.i_decode_data[0].RegWrite;
    assign wr1   = rn.i_decode_data[1].RegWrite;
    assign dst0  = rn.i_decode_data[0].ARegAddrDst;
    assign dst1  = rn.i_decode_data[1].ARegAddrDst;
    assign src00 = rn.i_decode_data[0].ARegAddrSrc0;
    assign src01 = rn.i_decode_data[0].ARegAddrSrc1;
    assign src10 = rn.i_decode_data[1].ARegAddrSrc0;
    assign src11 = rn.i_decode_data[1].ARegAddrSrc1;

    assign need0    = wr0 && (dst0 != 5'd0);
    assign need1    = wr1 && (dst1 != 5'd0);
    assign need_cnt = {1'b0, need0} + {1'b0, need1};

    // Retire returns: P0 is silently ignored, a return into a full list is dropped and flagged.
    preg_t            free0, free1;
    logic             req0, req1, push0, push1, drop0, drop1;
    logic [CNT_W-1:0] count_lane1;
    logic [1:0]       push_cnt;

    assign free0       = rn.i_free_preg[0];
    assign free1       = rn.i_free_preg[1];
    assign req0        = rn.i_free_valid[0] && (free0 != '0);
    assign req1        = rn.i_free_valid[1] && (free1 != '0);
    assign push0       = req0 && (count_reg != FL_FULL);
    assign drop0       = req0 && (count_reg == FL_FULL);
    assign count_lane1 = count_reg + CNT_W'(push0);
    assign push1       = req1 && (count_lane1 != FL_FULL);
    assign drop1       = req1 && (count_lane1 == FL_FULL);
    assign push_cnt    = {1'b0, push0} + {1'b0, push1};

    logic [CNT_W-1:0] avail_cnt;
    logic             ready_c, accept;
    logic [1:0]       pop_cnt;
    preg_t            head1, tail1;
    preg_t            pop_first, pop_second;

`ifdef RENAME_FREE_BYPASS_EN
    preg_t push_first;
    assign avail_cnt  = count_reg + CNT_W'(push_cnt);
    assign push_first = push0 ? free0 : free1;
    assign pop_first  = (count_reg != '0) ? fl_rd[head_reg] : push_first;
    assign pop_second = (count_reg >= CNT_W'(2)) ? fl_rd[head1] :
                        (count_reg == CNT_W'(1)) ? push_first : free1;
`else
    assign avail_cnt  = count_reg;
    assign pop_first  = fl_rd[head_reg];
    assign pop_second = fl_rd[head1];
`endif

    assign ready_c = (!valid_reg || rn.i_ready) && (avail_cnt >= CNT_W'(need_cnt));
    assign accept  = rn.i_valid && ready_c;
    assign pop_cnt = accept ? need_cnt : 2'd0;
    assign head1   = fl_advance(head_reg, 2'd1);
    assign tail1   = fl_advance(tail_reg, {1'b0, push0});

    preg_t pdst0_c, pdst1_c, pold0_c, pold1_c;
    preg_t psrc00_c, psrc01_c, psrc10_c, psrc11_c;

    // Slot1 sees slot0's fresh allocation for both its sources and its old-dst mapping.
    always_comb begin
        pdst0_c  = need0 ? pop_first : '0;
        pdst1_c  = '0;
        if (need1) pdst1_c = need0 ? pop_second : pop_first;
        psrc00_c = rat_rd[src00];
        psrc01_c = rat_rd[src01];
        psrc10_c = (need0 && (src10 == dst0)) ? pdst0_c : rat_rd[src10];
        psrc11_c = (need0 && (src11 == dst0)) ? pdst0_c : rat_rd[src11];
        pold0_c  = need0 ? rat_rd[dst0] : '0;
        pold1_c  = '0;
        if (need1) pold1_c = (need0 && (dst1 == dst0)) ? pdst0_c : rat_rd[dst1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AREGS; gi++) begin : g_rat
            preg_t map_reg;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    map_reg <= preg_t'(gi);
                end else if (accept) begin
                    if (need1 && (dst1 == 5'(gi)))      map_reg <= pdst1_c;
                    else if (need0 && (dst0 == 5'(gi))) map_reg <= pdst0_c;
                end
            end
            assign rat_rd[gi] = map_reg;
        end

        for (gi = 0; gi < FL_DEPTH; gi++) begin : g_fl
            preg_t entry_reg;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    entry_reg <= preg_t'(NUM_AREGS + gi);
                end else if (push0 && (tail_reg == preg_t'(gi))) begin
                    entry_reg <= free0;
                end else if (push1 && (tail1 == preg_t'(gi))) begin
                    entry_reg <= free1;
                end
            end
            assign fl_rd[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= FL_FULL;
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= fl_advance(head_reg, pop_cnt);
            tail_reg     <= fl_advance(tail_reg, push_cnt);
            count_reg    <= count_reg - CNT_W'(pop_cnt) + CNT_W'(push_cnt);
            overflow_reg <= overflow_reg | drop0 | drop1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                data_reg[s]  <= '0;
                psrc0_reg[s] <= '0;
                psrc1_reg[s] <= '0;
                pdst_reg[s]  <= '0;
                pold_reg[s]  <= '0;
            end
        end else if (accept) begin
            valid_reg    <= 1'b1;
            data_reg[0]  <= rn.i_decode_data[0];
            data_reg[1]  <= rn.i_decode_data[1];
            psrc0_reg[0] <= psrc00_c;
            psrc1_reg[0] <= psrc01_c;
            psrc0_reg[1] <= psrc10_c;
            psrc1_reg[1] <= psrc11_c;
            pdst_reg[0]  <= pdst0_c;
            pdst_reg[1]  <= pdst1_c;
            pold_reg[0]  <= pold0_c;
            pold_reg[1]  <= pold1_c;
        end else if (rn.i_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign rn.o_ready         = ready_c;
    assign rn.o_valid         = valid_reg;
    assign rn.o_decode_data   = data_reg;
    assign rn.o_psrc0         = psrc0_reg;
    assign rn.o_psrc1         = psrc1_reg;
    assign rn.o_pdst          = pdst_reg;
    assign rn.o_pold          = pold_reg;
    assign rn.o_free_count    = count_reg;
    assign rn.o_free_overflow = overflow_reg;
endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: vector table for single groups, hand sequences for
// free-list exhaustion, stalls, overflow/wrap and mid-operation reset.
module tb_rename_stage;
    import Types::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    rename_stage_if #(.PREG_W(7)) rn ();

    rename_stage dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .rn    (rn)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        decode_struct d0, d1;
        int ps00, ps01, ps10, ps11;
        int pd0, pd1, po0, po1, cnt;
    } vec_t;

    vec_t vt [6];

    function automatic decode_struct mk(input logic rw, input int dst, input int s0,
                                        input int s1, input int imm);
        decode_struct d;
        d.RegWrite     = rw;
        d.ARegAddrDst  = 5'(dst);
        d.ARegAddrSrc0 = 5'(s0);
        d.ARegAddrSrc1 = 5'(s1);
        d.AluOp        = 4'(dst + s0);
        d.UseImm       = (imm != 0);
        d.Imm          = 16'(imm);
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input decode_struct d0, input decode_struct d1);
        rn.i_decode_data[0] = d0;
        rn.i_decode_data[1] = d1;
        rn.i_valid          = 1'b1;
    endtask

    task automatic do_reset();
        rn.i_valid      = 1'b0;
        rn.i_free_valid = 2'b00;
        i_rst           = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q[$];
        int rat_m [32];
        int prev_old;
        int a, exp_pd, exp_po;

        vt[0] = '{mk(1,5,1,2,0), mk(1,6,5,0,4),   1,  2, 32,  0, 32, 33, 5,  6, 94};
        vt[1] = '{mk(1,7,5,6,0), mk(1,7,7,1,0),  32, 33, 34,  1, 34, 35, 7, 34, 92};
        vt[2] = '{mk(1,8,7,0,0), mk(0,0,8,7,0),  35,  0, 36, 35, 36,  0, 8,  0, 91};
        vt[3] = '{mk(0,0,0,0,0), mk(0,0,0,0,0),   0,  0,  0,  0,  0,  0, 0,  0, 91};
        vt[4] = '{mk(1,0,5,6,0), mk(1,5,0,5,0),  32, 33,  0, 32,  0, 37, 0, 32, 90};
        vt[5] = '{mk(1,9,5,9,0), mk(1,5,9,9,0),  37,  9, 38, 38, 38, 39, 9, 37, 88};

        rn.i_ready          = 1'b1;
        rn.i_decode_data[0] = '0;
        rn.i_decode_data[1] = '0;
        rn.i_free_preg[0]   = '0;
        rn.i_free_preg[1]   = '0;
        do_reset();

        // Reset state
        chk("rst_valid", rn.o_valid, 0);
        chk("rst_count", rn.o_free_count, 96);
        chk("rst_ovf", rn.o_free_overflow, 0);
        chk("rst_pdst0", rn.o_pdst[0], 0);
        chk("rst_pold1", rn.o_pold[1], 0);
        chk("rst_ready", rn.o_ready, 1);
        $display("reset: count %0d valid %0d", rn.o_free_count, rn.o_valid);

        // Table-driven single groups, RAT state carries from one vector to the next
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].d0, vt[i].d1);
            #1;
            chk("vec_ready", rn.o_ready, 1);
            step();
            rn.i_valid = 1'b0;
            chk("vec_valid", rn.o_valid, 1);
            chk("vec_psrc00", rn.o_psrc0[0], 64'(vt[i].ps00));
            chk("vec_psrc01", rn.o_psrc1[0], 64'(vt[i].ps01));
            chk("vec_psrc10", rn.o_psrc0[1], 64'(vt[i].ps10));
            chk("vec_psrc11", rn.o_psrc1[1], 64'(vt[i].ps11));
            chk("vec_pdst0", rn.o_pdst[0], 64'(vt[i].pd0));
            chk("vec_pdst1", rn.o_pdst[1], 64'(vt[i].pd1));
            chk("vec_pold0", rn.o_pold[0], 64'(vt[i].po0));
            chk("vec_pold1", rn.o_pold[1], 64'(vt[i].po1));
            chk("vec_count", rn.o_free_count, 64'(vt[i].cnt));
            chk("vec_data0", rn.o_decode_data[0], vt[i].d0);
            chk("vec_data1", rn.o_decode_data[1], vt[i].d1);
            $display("vec %0d: psrc {%0d,%0d},{%0d,%0d} pdst {%0d,%0d} pold {%0d,%0d} count %0d",
                     i, rn.o_psrc0[0], rn.o_psrc1[0], rn.o_psrc0[1], rn.o_psrc1[1],
                     rn.o_pdst[0], rn.o_pdst[1], rn.o_pold[0], rn.o_pold[1], rn.o_free_count);
        end

        // Drain the free list down to one entry, then a 2-alloc group must wait
        do_reset();
        for (int i = 0; i < 47; i++) begin
            drive(mk(1,1,0,0,0), mk(1,2,0,0,0));
            step();
        end
        drive(mk(1,3,0,0,0), mk(0,0,0,0,0));
        step();
        chk("drain_count1", rn.o_free_count, 1);
        drive(mk(1,4,0,0,0), mk(1,5,0,0,0));
        #1;
        chk("drain_ready_lo", rn.o_ready, 0);
        step();
        chk("drain_valid_lo", rn.o_valid, 0);
        rn.i_free_valid   = 2'b01;
        rn.i_free_preg[0] = 7'd1;
        #1;
`ifdef RENAME_FREE_BYPASS_EN
        chk("drain_ready_byp", rn.o_ready, 1);
        step();
        rn.i_free_valid = 2'b00;
`else
        chk("drain_ready_free", rn.o_ready, 0);
        step();
        rn.i_free_valid = 2'b00;
        chk("drain_valid_wait", rn.o_valid, 0);
        chk("drain_count2", rn.o_free_count, 2);
        #1;
        chk("drain_ready_hi", rn.o_ready, 1);
        step();
`endif
        rn.i_valid = 1'b0;
        chk("drain_valid", rn.o_valid, 1);
        chk("drain_pdst0", rn.o_pdst[0], 127);
        chk("drain_pdst1", rn.o_pdst[1], 1);
        chk("drain_count0", rn.o_free_count, 0);
        $display("drain: pdst {%0d,%0d} count %0d", rn.o_pdst[0], rn.o_pdst[1], rn.o_free_count);

        // Downstream stall holds the bundle for three cycles
        do_reset();
        rn.i_ready = 1'b0;
        drive(mk(1,5,1,2,0), mk(0,0,0,0,0));
        step();
        drive(mk(1,6,5,0,0), mk(0,0,0,0,0));
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", rn.o_ready, 0);
            step();
            chk("stall_valid", rn.o_valid, 1);
            chk("stall_pdst0", rn.o_pdst[0], 32);
            chk("stall_pold0", rn.o_pold[0], 5);
            chk("stall_count", rn.o_free_count, 95);
            $display("stall %0d: pdst0 %0d count %0d", i, rn.o_pdst[0], rn.o_free_count);
        end
        rn.i_ready = 1'b1;
        #1;
        chk("stall_release", rn.o_ready, 1);
        step();
        rn.i_valid = 1'b0;
        chk("flow_pdst0", rn.o_pdst[0], 33);
        chk("flow_psrc00", rn.o_psrc0[0], 32);
        chk("flow_pold0", rn.o_pold[0], 6);
        chk("flow_count", rn.o_free_count, 94);

        // Overflow on a full list, then 200 alloc/free pairs against a queue model
        do_reset();
        rn.i_free_valid   = 2'b11;
        rn.i_free_preg[0] = 7'd1;
        rn.i_free_preg[1] = 7'd2;
        step();
        rn.i_free_valid = 2'b00;
        chk("ovf_count", rn.o_free_count, 96);
        chk("ovf_flag", rn.o_free_overflow, 1);
        q.delete();
        for (int p = 32; p < 128; p++) q.push_back(p);
        for (int r = 0; r < 32; r++) rat_m[r] = r;
        prev_old = 0;
        for (int it = 0; it < 200; it++) begin
            a = 1 + (it % 31);
            drive(mk(1,a,a,0,0), mk(0,0,0,0,0));
            rn.i_free_valid   = (prev_old != 0) ? 2'b01 : 2'b00;
            rn.i_free_preg[0] = 7'(prev_old);
            exp_pd = q.pop_front();
            exp_po = rat_m[a];
            if (prev_old != 0) q.push_back(prev_old);
            step();
            chk("wrap_pdst0", rn.o_pdst[0], 64'(exp_pd));
            chk("wrap_pold0", rn.o_pold[0], 64'(exp_po));
            chk("wrap_psrc00", rn.o_psrc0[0], 64'(exp_po));
            $display("pair %0d: x%0d -> P%0d old P%0d count %0d",
                     it, a, rn.o_pdst[0], rn.o_pold[0], rn.o_free_count);
            rat_m[a] = exp_pd;
            prev_old = exp_po;
        end
        rn.i_valid        = 1'b0;
        rn.i_free_valid   = 2'b01;
        rn.i_free_preg[0] = 7'(prev_old);
        q.push_back(prev_old);
        step();
        rn.i_free_valid = 2'b00;
        chk("wrap_count_final", rn.o_free_count, 64'(q.size()));
        chk("wrap_ovf_sticky", rn.o_free_overflow, 1);

        // Reset with a held group discards it and restores identity mapping
        rn.i_ready = 1'b0;
        drive(mk(1,5,1,0,0), mk(0,0,0,0,0));
        step();
        rn.i_valid = 1'b0;
        chk("held_valid", rn.o_valid, 1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("mrst_valid", rn.o_valid, 0);
        chk("mrst_count", rn.o_free_count, 96);
        chk("mrst_ovf", rn.o_free_overflow, 0);
        chk("mrst_pdst0", rn.o_pdst[0], 0);
        chk("mrst_data0", rn.o_decode_data[0], 0);
        rn.i_ready = 1'b1;
        drive(mk(0,0,5,6,0), mk(0,0,7,31,0));
        step();
        rn.i_valid = 1'b0;
        chk("mrst_rat5", rn.o_psrc0[0], 5);
        chk("mrst_rat6", rn.o_psrc1[0], 6);
        chk("mrst_rat7", rn.o_psrc0[1], 7);
        chk("mrst_rat31", rn.o_psrc1[1], 31);
        $display("post-reset: psrc {%0d,%0d},{%0d,%0d}",
                 rn.o_psrc0[0], rn.o_psrc1[0], rn.o_psrc0[1], rn.o_psrc1[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
